// File: rtl/alu.sv
// Two's-complement ALU with one-cycle registered latency.
// Opcodes: add, subtract, bitwise AND, bitwise OR. Also produces signed-overflow and zero flags.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] result,
  output logic             out_valid
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] or_bits;
  logic             is_sub;
  logic             arith_ovf;

  logic [WIDTH-1:0] result_reg, result_next;
  logic             overflow_reg, overflow_next;
  logic             zero_reg, zero_next;
  logic             out_valid_reg;

  // Subtraction reuses the adder: A + ~B + 1.
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~B : B;
  assign sum    = A + b_eff + WIDTH'(is_sub);

  // Add and subtract both overflow when the adder inputs share a sign and the sum flips it.
  assign arith_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_logic
      assign and_bits[gi] = A[gi] & B[gi];
      assign or_bits[gi]  = A[gi] | B[gi];
    end
  endgenerate

  always_comb begin
    result_next   = sum;
    overflow_next = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result_next   = sum;
        overflow_next = arith_ovf;
      end
      OP_AND: result_next = and_bits;
      OP_OR:  result_next = or_bits;
      default: begin
        result_next   = sum;
        overflow_next = 1'b0;
      end
    endcase
    zero_next = (result_next == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        result_reg   <= result_next;
        overflow_reg <= overflow_next;
        zero_reg     <= zero_next;
      end
    end
  end

  assign result    = result_reg;
  assign overflow  = overflow_reg;
  assign zero      = zero_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the 4-bit alu: reset, arithmetic, overflow, logic ops, hold and reset mid-stream.
module tb_alu;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       op;
  logic             in_valid;
  logic             overflow;
  logic             zero;
  logic [WIDTH-1:0] result;
  logic             out_valid;

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(A),
    .B(B),
    .op(op),
    .in_valid(in_valid),
    .overflow(overflow),
    .zero(zero),
    .result(result),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] er, input logic eo,
                            input logic ez, input logic ev);
    check_eq({tag, ".result"}, 32'(result), 32'(er));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(eo));
    check_eq({tag, ".zero"}, 32'(zero), 32'(ez));
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    $display("txn %-8s A=%0h B=%0h op=%0d -> result=%0h ovf=%0b zero=%0b vld=%0b",
             tag, A, B, op, result, overflow, zero, out_valid);
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] o, input logic v);
    @(negedge clk);
    rst_n = r; A = a; B = b; op = o; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic [1:0] o, input logic [3:0] er, input logic eo, input logic ez);
    drive(1'b1, a, b, o, 1'b1);
    check_outs(tag, er, eo, ez, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; A = 4'd2; B = 4'd3; op = 2'b00; in_valid = 1'b1;

    // Reset wins over in_valid for two edges.
    drive(1'b0, 4'd2, 4'd3, 2'b00, 1'b1);
    check_outs("rst0", 4'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'd2, 4'd3, 2'b00, 1'b1);
    check_outs("rst1", 4'h0, 1'b0, 1'b1, 1'b0);

    run("add23",  4'd2, 4'd3, 2'b00, 4'd5, 1'b0, 1'b0);
    run("sub23",  4'd2, 4'd3, 2'b01, 4'hF, 1'b0, 1'b0);
    run("sub00",  4'd0, 4'd0, 2'b01, 4'h0, 1'b0, 1'b1);
    run("add44",  4'd4, 4'd4, 2'b00, 4'h8, 1'b1, 1'b0);
    run("addm8",  4'h8, 4'h8, 2'b00, 4'h0, 1'b1, 1'b1);
    run("subm8_1", 4'h8, 4'h1, 2'b01, 4'h7, 1'b1, 1'b0);
    run("sub7_m1", 4'h7, 4'hF, 2'b01, 4'h8, 1'b1, 1'b0);
    run("and35",  4'd3, 4'd5, 2'b10, 4'h1, 1'b0, 1'b0);
    run("or33",   4'd3, 4'd3, 2'b11, 4'h3, 1'b0, 1'b0);
    run("and52",  4'd5, 4'd2, 2'b10, 4'h0, 1'b0, 1'b1);
    run("add_m1_1", 4'hF, 4'h1, 2'b00, 4'h0, 1'b0, 1'b1);
    run("sub_m1_7", 4'hF, 4'h7, 2'b01, 4'h8, 1'b0, 1'b0);

    // Hold: outputs freeze while in_valid is low, regardless of inputs.
    run("add23b", 4'd2, 4'd3, 2'b00, 4'd5, 1'b0, 1'b0);
    drive(1'b1, 4'h8, 4'h8, 2'b00, 1'b0);
    check_outs("hold0", 4'd5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 2'b01, 1'b0);
    check_outs("hold1", 4'd5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h7, 4'hF, 2'b11, 1'b0);
    check_outs("hold2", 4'd5, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream discards the computation on that edge.
    run("add44b", 4'd4, 4'd4, 2'b00, 4'h8, 1'b1, 1'b0);
    drive(1'b0, 4'd2, 4'd3, 2'b00, 1'b1);
    check_outs("rstmid", 4'h0, 1'b0, 1'b1, 1'b0);
    run("after", 4'd1, 4'd1, 2'b00, 4'h2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=0 expected=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Parameterised two's-complement ALU with registered outputs.
- Computes add, subtract, AND or OR of two WIDTH-bit operands, selected by a 2-bit opcode.
- Also produces signed-overflow and zero flags.
- Sits in the datapath as a single-cycle-latency execution unit; flags feed branch/condition logic downstream.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- A  input  WIDTH  operand A, two's-complement signed.
- B  input  WIDTH  operand B, two's-complement signed.
- op  input  2  operation select.
- in_valid  input  1  qualifies A/B/op on this edge.
- overflow  output  1  registered signed-overflow flag.
- zero  output  1  registered flag, 1 when result is all zeros.
- result  output  WIDTH  registered operation result.
- out_valid  output  1  high for one cycle when result/flags hold a new computation.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising clk edge.
- Reset (rst_n=0 at a rising edge):
  - result=0, overflow=0, zero=1, out_valid=0.
  - Reset has priority over in_valid.
  - A computation sampled on the same edge is discarded.
- Opcode map:
  - 00: ADD, result = A+B.
  - 01: SUB, result = A-B, implemented as A + ~B + 1.
  - 10: AND, bitwise.
  - 11: OR, bitwise.
- Arithmetic: result is truncated to WIDTH bits (wrap-around); carry-out is not exported.
- Overflow:
  - ADD: 1 when A and B have the same sign and the result sign differs.
  - SUB: 1 when A and B have different signs and the result sign differs from A.
  - AND/OR: overflow = 0.
- zero = 1 iff the registered result is all zeros, regardless of op; it is independent of overflow (e.g. wrap to 0 with overflow=1 gives zero=1).
- Latency and handshake:
  - On a rising edge with rst_n=1 and in_valid=1, compute from the current A/B/op and register result/overflow/zero.
  - On that same edge, out_valid <= 1.
  - Outputs are visible one cycle after the sampling edge.
- Hold: on an edge with in_valid=0, result/overflow/zero keep their previous values and out_valid <= 0.
- Back-to-back: in_valid high on consecutive edges gives one result per cycle, with no bubbles and no stalls.
- No combinational path from inputs to outputs.
- Any input change between edges has no effect on outputs.
- op is always decoded; no illegal codes.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1 -> result=0, overflow=0, zero=1, out_valid=0; release, then A=2,B=3,op=00,in_valid=1 -> next cycle result=5, overflow=0, zero=0, out_valid=1.
- SUB and zero: A=2,B=3,op=01 -> result=4'b1111 (-1), overflow=0, zero=0; then A=0,B=0,op=01 -> result=0, zero=1, overflow=0.
- ADD overflow: A=4,B=4,op=00 -> result=4'b1000 (-8), overflow=1, zero=0; A=-8,B=-8,op=00 -> result=0, overflow=1, zero=1.
- SUB overflow: A=-8,B=1,op=01 -> result=7, overflow=1; A=7,B=-1,op=01 -> result=-8, overflow=1.
- Logic ops: A=3,B=5,op=10 -> result=1, overflow=0; A=3,B=3,op=11 -> result=3, overflow=0; A=5,B=2,op=10 -> result=0, zero=1.
- Hold/handshake: compute 2+3, then drop in_valid and change A/B/op for 3 cycles -> result stays 5, out_valid=0; assert rst_n=0 mid-stream with in_valid=1 -> outputs return to reset values on that edge.
